// File: rtl/joypad_pkg.sv
// Shared types and constants for the NES joypad scan controller.
package joypad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LATCH = 3'd1,
      ST_LOW   = 3'd2,
      ST_HIGH  = 3'd3,
      ST_DONE  = 3'd4
   } jp_state_t;

   localparam logic [15:0] JP1_ADDR = 16'h4016;
   localparam logic [15:0] JP2_ADDR = 16'h4017;

   // Button positions in the snapshot, in the order the pad shifts them out.
   localparam int unsigned BTN_A      = 0;
   localparam int unsigned BTN_B      = 1;
   localparam int unsigned BTN_SELECT = 2;
   localparam int unsigned BTN_START  = 3;
   localparam int unsigned BTN_UP     = 4;
   localparam int unsigned BTN_DOWN   = 5;
   localparam int unsigned BTN_LEFT   = 6;
   localparam int unsigned BTN_RIGHT  = 7;

   localparam int unsigned NUM_BUTTONS = 8;

   function automatic logic is_pad_addr(input logic [15:0] a);
      return (a == JP1_ADDR) || (a == JP2_ADDR);
   endfunction

endpackage

// File: rtl/joypad_shadow.sv
// CPU-side shadow of one pad: reloads while strobing, otherwise shifts out
// one button per read and fills with 1s like a real 4021 chain.
module joypad_shadow
   import joypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       strobe,
   input  logic       shift,
   input  logic [7:0] load_val,
   output logic       data_out
);

   logic [NUM_BUTTONS-1:0] r_shift;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (strobe) begin
         r_shift <= load_val;
      end else if (shift) begin
         r_shift <= {1'b1, r_shift[NUM_BUTTONS-1:1]};
      end
   end

   assign data_out = r_shift[BTN_A];

endmodule

// File: rtl/joypad_scanner.sv
// Autonomous two-port NES pad scanner with CPU shadow registers at $4016/$4017.
// Build option: define JOYPAD_DEBOUNCE_EN to publish only after two matching scans.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for scan_req or a pending request
//   ST_LATCH | jp_latch high, pads parallel-load their buttons
//   ST_LOW   | pad clocks low; last cycle samples bit[idx]
//   ST_HIGH  | pad clocks high; pads advance to the next bit
//   ST_DONE  | snapshot published, scan_done pulses
module joypad_scanner
   import joypad_pkg::*;
#(
   parameter int unsigned LATCH_CYCLES = 12,
   parameter int unsigned HALF_CYCLES  = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scan_req,
   input  logic        wren,
   input  logic        rden,
   input  logic [15:0] addr,
   input  logic [7:0]  from_cpu,
   output logic [7:0]  to_cpu,
   input  logic        jp1_data,
   input  logic        jp2_data,
   output logic        jp_latch,
   output logic        jp1_clk,
   output logic        jp2_clk,
   output logic [7:0]  pad1_buttons,
   output logic [7:0]  pad2_buttons,
   output logic        scan_done,
   output logic        busy
);

   localparam int unsigned CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX   = 3'(BTN_RIGHT);

   jp_state_t        r_state;
   jp_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_tc;
   logic [2:0]       r_idx;
   logic             r_pending;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [7:0]       r_cap1;
   logic [7:0]       r_cap2;
   logic [7:0]       r_pad1;
   logic [7:0]       r_pad2;
   logic             r_jp_latch;
   logic             r_jp_clk;
   logic             r_scan_done;
   logic             r_busy;
   logic             r_strobe;
   logic             w_enter_done;
   logic             w_ld1;
   logic             w_ld2;
   logic             w_rd1;
   logic             w_rd2;
   logic             w_sh1_bit;
   logic             w_sh2_bit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tc        = (r_cnt == '0);
      case (r_state)
         ST_IDLE:  if (scan_req || r_pending) w_state_nxt = ST_LATCH;
         ST_LATCH: if (w_tc) w_state_nxt = ST_LOW;
         ST_LOW:   if (w_tc) w_state_nxt = ST_HIGH;
         ST_HIGH:  if (w_tc) w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_LOW;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Phase timer reloads on every state change and counts down to terminal zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         case (w_state_nxt)
            ST_LATCH:        r_cnt <= LATCH_LOAD;
            ST_LOW, ST_HIGH: r_cnt <= HALF_LOAD;
            default:         r_cnt <= '0;
         endcase
      end else if (!w_tc) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (r_state == ST_LATCH && w_state_nxt == ST_LOW) begin
         r_idx <= '0;
      end else if (r_state == ST_HIGH && w_state_nxt == ST_LOW) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_pending <= 1'b0;
      end else if (scan_req) begin
         r_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {r_sync1[0], jp1_data};
         r_sync2 <= {r_sync2[0], jp2_data};
      end
   end

   // Pad data is active-low; store pressed = 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cap1 <= '0;
         r_cap2 <= '0;
      end else if (r_state == ST_LOW && w_tc) begin
         r_cap1[r_idx] <= ~r_sync1[1];
         r_cap2[r_idx] <= ~r_sync2[1];
      end
   end

   assign w_enter_done = (r_state == ST_HIGH) && (w_state_nxt == ST_DONE);

`ifdef JOYPAD_DEBOUNCE_EN
   logic [7:0] r_prev1;
   logic [7:0] r_prev2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev1 <= '0;
         r_prev2 <= '0;
      end else if (w_enter_done) begin
         r_prev1 <= r_cap1;
         r_prev2 <= r_cap2;
      end
   end

   assign w_ld1 = (r_cap1 == r_prev1);
   assign w_ld2 = (r_cap2 == r_prev2);
`else
   assign w_ld1 = 1'b1;
   assign w_ld2 = 1'b1;
`endif

   // Snapshot is loaded on entry to DONE so it is valid while scan_done is high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pad1      <= '0;
         r_pad2      <= '0;
         r_scan_done <= 1'b0;
      end else begin
         r_scan_done <= w_enter_done && (w_ld1 || w_ld2);
         if (w_enter_done && w_ld1) r_pad1 <= r_cap1;
         if (w_enter_done && w_ld2) r_pad2 <= r_cap2;
      end
   end

   // Pad-side outputs are registered from the next state so the wires never glitch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_jp_latch <= 1'b0;
         r_jp_clk   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_jp_latch <= (w_state_nxt == ST_LATCH);
         r_jp_clk   <= (w_state_nxt == ST_HIGH);
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_strobe <= 1'b0;
      end else if (wren && addr == JP1_ADDR) begin
         r_strobe <= from_cpu[0];
      end
   end

   assign w_rd1 = rden && (addr == JP1_ADDR);
   assign w_rd2 = rden && (addr == JP2_ADDR);

   joypad_shadow u_shadow1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe   (r_strobe),
      .shift    (w_rd1),
      .load_val (r_pad1),
      .data_out (w_sh1_bit)
   );

   joypad_shadow u_shadow2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .strobe   (r_strobe),
      .shift    (w_rd2),
      .load_val (r_pad2),
      .data_out (w_sh2_bit)
   );

   always_comb begin
      to_cpu = 8'h00;
      if (addr == JP1_ADDR) begin
         to_cpu = {1'b0, is_pad_addr(addr), 5'b0, w_sh1_bit};
      end else if (addr == JP2_ADDR) begin
         to_cpu = {1'b0, is_pad_addr(addr), 5'b0, w_sh2_bit};
      end
   end

   assign jp_latch     = r_jp_latch;
   assign jp1_clk      = r_jp_clk;
   assign jp2_clk      = r_jp_clk;
   assign pad1_buttons = r_pad1;
   assign pad2_buttons = r_pad2;
   assign scan_done    = r_scan_done;
   assign busy         = r_busy;

endmodule

// File: tb/tb_joypad_scanner.sv
// Randomized self-checking bench for joypad_scanner with behavioural pad and CPU models.
module tb_joypad_scanner;

   localparam int LATCH    = 12;
   localparam int HALF     = 6;
   localparam int SCAN_LEN = LATCH + 16 * HALF + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_req = 1'b0;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  from_cpu = 8'h00;
   logic [7:0]  to_cpu;
   logic        jp1_data;
   logic        jp2_data;
   logic        jp_latch;
   logic        jp1_clk;
   logic        jp2_clk;
   logic [7:0]  pad1_buttons;
   logic [7:0]  pad2_buttons;
   logic        scan_done;
   logic        busy;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference state: what the pads show and what the snapshot should be.
   logic [7:0] pad1_state = 8'h00;
   logic [7:0] pad2_state = 8'h00;
   logic [7:0] exp1 = 8'h00;
   logic [7:0] exp2 = 8'h00;
   logic [7:0] prev1 = 8'h00;
   logic [7:0] prev2 = 8'h00;

   joypad_scanner #(.LATCH_CYCLES(LATCH), .HALF_CYCLES(HALF)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .scan_req     (scan_req),
      .wren         (wren),
      .rden         (rden),
      .addr         (addr),
      .from_cpu     (from_cpu),
      .to_cpu       (to_cpu),
      .jp1_data     (jp1_data),
      .jp2_data     (jp2_data),
      .jp_latch     (jp_latch),
      .jp1_clk      (jp1_clk),
      .jp2_clk      (jp2_clk),
      .pad1_buttons (pad1_buttons),
      .pad2_buttons (pad2_buttons),
      .scan_done    (scan_done),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Pad model: latch captures the buttons, each rising pad clock advances one bit.
   logic [7:0] pad1_lat = 8'h00;
   logic [7:0] pad2_lat = 8'h00;
   logic [3:0] p1_idx = 4'd8;
   logic [3:0] p2_idx = 4'd8;

   always @(posedge jp_latch or posedge jp1_clk) begin
      if (jp_latch) begin
         p1_idx   <= 4'd0;
         pad1_lat <= pad1_state;
      end else if (p1_idx < 4'd8) begin
         p1_idx <= p1_idx + 4'd1;
      end
   end

   always @(posedge jp_latch or posedge jp2_clk) begin
      if (jp_latch) begin
         p2_idx   <= 4'd0;
         pad2_lat <= pad2_state;
      end else if (p2_idx < 4'd8) begin
         p2_idx <= p2_idx + 4'd1;
      end
   end

   assign jp1_data = !((p1_idx < 4'd8) && pad1_lat[p1_idx[2:0]]);
   assign jp2_data = !((p2_idx < 4'd8) && pad2_lat[p2_idx[2:0]]);

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; from_cpu = d; wren = 1'b1;
      @(posedge clk); #1;
      wren = 1'b0; from_cpu = 8'h00; addr = 16'h0000;
   endtask

   task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
      addr = a; rden = 1'b1;
      #2 d = to_cpu;
      @(posedge clk); #1;
      rden = 1'b0; addr = 16'h0000;
   endtask

   function automatic logic [7:0] rd_exp(input logic [7:0] v, input int k);
      logic bitv;
      bitv = (k < 8) ? v[k] : 1'b1;
      return {7'b0100000, bitv};
   endfunction

   // Runs one full scan, checking timing, pad-side waveform and the published snapshot.
   task automatic do_scan(input logic [7:0] v1, input logic [7:0] v2);
      int latch_cnt = 0, rise1 = 0, rise2 = 0, run1 = 0, run2 = 0, good1 = 0, good2 = 0;
      int done_cnt = 0, done_cyc = 0;
      logic pj1 = 1'b0, pj2 = 1'b0, busy_first = 1'b0, busy_after = 1'b1;
      logic [7:0] snap1 = 8'h00, snap2 = 8'h00;
      logic ld1, ld2, exp_done;
`ifdef JOYPAD_DEBOUNCE_EN
      ld1 = (v1 == prev1);
      ld2 = (v2 == prev2);
`else
      ld1 = 1'b1;
      ld2 = 1'b1;
`endif
      prev1 = v1; prev2 = v2;
      if (ld1) exp1 = v1;
      if (ld2) exp2 = v2;
      exp_done = ld1 || ld2;
      pad1_state = v1; pad2_state = v2;
      scan_req = 1'b1;
      @(posedge clk); #1;
      scan_req = 1'b0;
      for (int cyc = 1; cyc <= SCAN_LEN + 3; cyc++) begin
         @(negedge clk);
         if (cyc == 1) busy_first = busy;
         if (cyc == SCAN_LEN + 1) busy_after = busy;
         if (jp_latch) latch_cnt++;
         if (jp1_clk) begin
            if (!pj1) rise1++;
            run1++;
         end else begin
            if (pj1 && run1 == HALF) good1++;
            run1 = 0;
         end
         if (jp2_clk) begin
            if (!pj2) rise2++;
            run2++;
         end else begin
            if (pj2 && run2 == HALF) good2++;
            run2 = 0;
         end
         pj1 = jp1_clk; pj2 = jp2_clk;
         if (scan_done) begin
            done_cnt++;
            done_cyc = cyc;
            snap1 = pad1_buttons;
            snap2 = pad2_buttons;
         end
      end
      check("latch_cycles", latch_cnt, LATCH);
      check("jp1_pulses", rise1, 8);
      check("jp1_high_len", good1, 8);
      check("jp2_pulses", rise2, 8);
      check("jp2_high_len", good2, 8);
      check("busy_start", busy_first, 1'b1);
      check("busy_end", busy_after, 1'b0);
      check("done_count", done_cnt, exp_done ? 1 : 0);
      if (exp_done) begin
         check("done_cycle", done_cyc, SCAN_LEN);
         check("snap1_at_done", snap1, exp1);
         check("snap2_at_done", snap2, exp2);
      end
      check("pad1_buttons", pad1_buttons, exp1);
      check("pad2_buttons", pad2_buttons, exp2);
      @(posedge clk); #1;
   endtask

   // Reload shadows, then random interleaved reads of both ports.
   task automatic read_test(input int nreads);
      int k1 = 0, k2 = 0;
      logic [7:0] d;
      logic [15:0] oa;
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      cpu_write(16'h4017, 8'h01);
      for (int i = 0; i < nreads; i++) begin
         if ($urandom_range(1) == 0) begin
            cpu_read(16'h4016, d);
            check("rd4016", d, rd_exp(exp1, k1));
            k1++;
         end else begin
            cpu_read(16'h4017, d);
            check("rd4017", d, rd_exp(exp2, k2));
            k2++;
         end
      end
      oa = 16'($urandom_range(16'hFFFF));
      if (oa == 16'h4016 || oa == 16'h4017) oa = 16'h4015;
      cpu_read(oa, d);
      check("rd_other", d, 8'h00);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] v1, v2, keep1;
      int done_cnt, rises, d1_cyc, r2_cyc, cyc;
      logic busy_gap;

      repeat (3) @(posedge clk);
      #1;
      check("rst_latch", jp_latch, 1'b0);
      check("rst_clks", {jp1_clk, jp2_clk}, 2'b00);
      check("rst_done_busy", {scan_done, busy}, 2'b00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_pad1", pad1_buttons, 8'h00);
      check("rst_pad2", pad2_buttons, 8'h00);
      addr = 16'h4016;
      #1 check("idle_to_cpu_4016", to_cpu, 8'h40);
      addr = 16'h1234;
      #1 check("idle_to_cpu_other", to_cpu, 8'h00);
      addr = 16'h0000;
      @(posedge clk); #1;

      // A + Right on pad 1, nothing on pad 2 (twice so the debounced build publishes).
      do_scan(8'h81, 8'h00);
      do_scan(8'h81, 8'h00);
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      for (int k = 0; k < 10; k++) begin
         cpu_read(16'h4016, d);
         check("seq81", d, rd_exp(8'h81, k));
      end

      // Strobe mode: reads return bit0 repeatedly without shifting.
      cpu_write(16'h4016, 8'h01);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         cpu_read(16'h4016, d);
         check("strobe_rd1", d, rd_exp(exp1, 0));
      end
      cpu_read(16'h4017, d);
      check("strobe_rd2", d, rd_exp(exp2, 0));
      cpu_write(16'h4016, 8'h00);

      // Alternating then repeated values exercise the debounce path.
      do_scan(8'h3C, 8'h11);
      do_scan(8'hC3, 8'h22);
      do_scan(8'hC3, 8'h22);
      read_test(12);

      // Read and write strobe in the same cycle: old bit returned, strobe applies afterwards.
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      cpu_read(16'h4016, d);
      check("rw_pre", d, rd_exp(exp1, 0));
      addr = 16'h4016; from_cpu = 8'h01; wren = 1'b1; rden = 1'b1;
      #2 d = to_cpu;
      @(posedge clk); #1;
      wren = 1'b0; rden = 1'b0; from_cpu = 8'h00;
      check("rw_same_cycle", d, rd_exp(exp1, 1));
      @(posedge clk); #1;
      cpu_read(16'h4016, d);
      check("rw_after_strobe", d, rd_exp(exp1, 0));
      cpu_write(16'h4016, 8'h00);

      // Snapshot update while not strobing leaves the shadow alone.
      cpu_write(16'h4016, 8'h01);
      cpu_write(16'h4016, 8'h00);
      keep1 = exp1;
      for (int k = 0; k < 3; k++) begin
         cpu_read(16'h4016, d);
         check("keep_pre", d, rd_exp(keep1, k));
      end
      do_scan(~keep1, 8'h5A);
      for (int k = 3; k < 9; k++) begin
         cpu_read(16'h4016, d);
         check("keep_post", d, rd_exp(keep1, k));
      end

      // Randomized scans; pad values repeat often enough to also publish under debounce.
      v1 = 8'h00; v2 = 8'h00;
      for (int n = 0; n < 14; n++) begin
         if ($urandom_range(2) != 0) v1 = 8'($urandom);
         if ($urandom_range(2) != 0) v2 = 8'($urandom);
         do_scan(v1, v2);
         if (n % 2 == 0) do_scan(v1, v2);
         read_test(10);
      end

      // Requests while busy merge into a single pending scan started after DONE.
      v1 = 8'h96; v2 = 8'h69;
      if (prev1 == v1 && prev2 == v2) begin
         exp1 = v1; exp2 = v2;
      end else begin
`ifndef JOYPAD_DEBOUNCE_EN
         exp1 = v1; exp2 = v2;
`endif
      end
      pad1_state = v1; pad2_state = v2;
      done_cnt = 0; rises = 0; d1_cyc = -1; r2_cyc = -1; busy_gap = 1'b1;
      @(negedge clk);
      scan_req = 1'b1;
      for (cyc = 1; cyc <= 2 * SCAN_LEN + 40; cyc++) begin
         @(negedge clk);
         scan_req = (cyc == 5 || cyc == 30 || cyc == 60);
         if (jp_latch && dut.r_jp_latch == 1'b1 && rises == 0) rises = 1;
         if (scan_done) begin
            done_cnt++;
            if (d1_cyc < 0) d1_cyc = cyc;
         end
         if (d1_cyc > 0 && cyc == d1_cyc + 1) busy_gap = busy;
         if (d1_cyc > 0 && cyc > d1_cyc && jp_latch && r2_cyc < 0) r2_cyc = cyc;
      end
      scan_req = 1'b0;
      @(posedge clk); #1;
`ifdef JOYPAD_DEBOUNCE_EN
      check("pend_done_le2", (done_cnt <= 2) ? 1 : 0, 1);
`else
      check("pend_done_count", done_cnt, 2);
`endif
      check("pend_second_start", r2_cyc - d1_cyc, 2);
      check("pend_busy_gap", busy_gap, 1'b0);
      prev1 = v1; prev2 = v2;
      exp1 = v1; exp2 = v2;
      check("pend_pad1", pad1_buttons, exp1);
      check("pend_pad2", pad2_buttons, exp2);

      // Reset mid-scan aborts without publishing anything.
      pad1_state = 8'hFF; pad2_state = 8'hFF;
      scan_req = 1'b1;
      @(posedge clk); #1;
      scan_req = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp1 = 8'h00; exp2 = 8'h00; prev1 = 8'h00; prev2 = 8'h00;
      done_cnt = 0;
      busy_gap = 1'b0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (scan_done) done_cnt++;
         busy_gap = busy_gap | busy | jp_latch | jp1_clk;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_quiet", busy_gap, 1'b0);
      check("abort_pad1", pad1_buttons, 8'h00);
      check("abort_pad2", pad2_buttons, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
